// File: rtl/kb_scr_pkg.sv
// Shared constants for the keyboard/screen FIFO driver: CSR bit positions,
// register-select codes, CSR reset values and a CSR packing helper.
package kb_scr_pkg;

  // CSR bit positions (bits 7:5 are reserved and read as zero)
  localparam int CSR_ENA = 4;
  localparam int CSR_OF  = 3;
  localparam int CSR_DBA = 2;
  localparam int CSR_IO  = 1;
  localparam int CSR_IE  = 0;

  // Register select codes on reg_sel_i
  localparam logic [1:0] SEL_KB_DATA  = 2'd0;
  localparam logic [1:0] SEL_KB_CSR   = 2'd1;
  localparam logic [1:0] SEL_SCR_DATA = 2'd2;
  localparam logic [1:0] SEL_SCR_CSR  = 2'd3;

  // CSR values seen right after reset (dba bits here describe empty FIFOs)
  localparam logic [7:0] KB_CSR_RST  = 8'h02;
  localparam logic [7:0] SCR_CSR_RST = 8'h04;

  // Writable / sticky CSR state; dba and io are derived, not stored
  typedef struct packed {
    logic ena;
    logic of;
    logic ie;
  } csr_ctl_t;

  // Assemble the 8-bit CSR image from stored state and live status
  function automatic logic [7:0] csr_pack(input csr_ctl_t c, input logic dba, input logic io);
    logic [7:0] v;
    v          = '0;
    v[CSR_ENA] = c.ena;
    v[CSR_OF]  = c.of;
    v[CSR_DBA] = dba;
    v[CSR_IO]  = io;
    v[CSR_IE]  = c.ie;
    return v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with zero-latency head. Push into a full FIFO and pop
// from an empty FIFO are ignored; full/empty reflect the pre-edge count so a
// concurrent pop never makes room for a push in the same cycle.
module sync_fifo
  #(parameter int W     = 8,
    parameter int DEPTH = 4)
  (input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/kb_scr_fifo_drv.sv
// Keyboard/screen device driver: keyboard bytes are buffered until the CPU
// reads them, screen bytes written by the CPU are buffered until the screen
// sink takes them. Two CSRs control enable, interrupt enable and overflow.
// Optional feature: define KB_SCR_IRQ_EN to generate irq_o; otherwise irq_o
// is tied low while the ie bits remain stored and readable.
module kb_scr_fifo_drv
  import kb_scr_pkg::*;
  #(parameter int DW        = 8,
    parameter int KB_DEPTH  = 4,
    parameter int SCR_DEPTH = 4)
  (input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] kb_data_i,
   input  logic          kb_valid_i,
   output logic          kb_ready_o,
   output logic [DW-1:0] scr_data_o,
   output logic          scr_valid_o,
   input  logic          scr_ready_i,
   input  logic [1:0]    reg_sel_i,
   input  logic          reg_wr_i,
   input  logic          reg_rd_i,
   input  logic [DW-1:0] reg_wdata_i,
   output logic [DW-1:0] reg_rdata_o,
   output logic          irq_o);

  localparam int KB_CW  = $clog2(KB_DEPTH) + 1;
  localparam int SCR_CW = $clog2(SCR_DEPTH) + 1;
  localparam logic [SCR_CW-1:0] SCR_FULL = SCR_CW'(SCR_DEPTH);

  csr_ctl_t          kb_ctl;
  csr_ctl_t          scr_ctl;

  logic [DW-1:0]     kb_head;
  logic              kb_full;
  logic              kb_empty;
  logic [KB_CW-1:0]  kb_count;
  logic              kb_push;
  logic              kb_pop;
  logic              kb_dba;

  logic [DW-1:0]     scr_head;
  logic              scr_full;
  logic              scr_empty;
  logic [SCR_CW-1:0] scr_count;
  logic              scr_push;
  logic              scr_pop;
  logic              scr_dba;

  logic              kb_csr_wr;
  logic              scr_csr_wr;
  logic [DW-1:0]     rd_mux;
  logic [DW-1:0]     rdata_p1;

  // Handshake and strobe decode
  assign kb_ready_o  = kb_ctl.ena;
  assign kb_push     = kb_valid_i & kb_ctl.ena;
  assign kb_pop      = reg_rd_i & (reg_sel_i == SEL_KB_DATA);
  assign scr_push    = reg_wr_i & (reg_sel_i == SEL_SCR_DATA);
  assign scr_valid_o = scr_ctl.ena & ~scr_empty;
  assign scr_pop     = scr_valid_o & scr_ready_i;
  assign scr_data_o  = scr_valid_o ? scr_head : '0;
  assign kb_csr_wr   = reg_wr_i & (reg_sel_i == SEL_KB_CSR);
  assign scr_csr_wr  = reg_wr_i & (reg_sel_i == SEL_SCR_CSR);

  // Live status: keyboard has data to read, screen has room to write
  assign kb_dba  = (kb_count != '0);
  assign scr_dba = (scr_count != SCR_FULL);

  sync_fifo #(.W(DW), .DEPTH(KB_DEPTH)) u_kb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (kb_push),
    .pop   (kb_pop),
    .din   (kb_data_i),
    .head  (kb_head),
    .full  (kb_full),
    .empty (kb_empty),
    .count (kb_count)
  );

  sync_fifo #(.W(DW), .DEPTH(SCR_DEPTH)) u_scr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (scr_push),
    .pop   (scr_pop),
    .din   (reg_wdata_i),
    .head  (scr_head),
    .full  (scr_full),
    .empty (scr_empty),
    .count (scr_count)
  );

  // Keyboard CSR: ena/ie written by CPU, of is W1C and set by a dropped byte
  always_ff @(posedge clk) begin
    if (rst) begin
      kb_ctl.ena <= KB_CSR_RST[CSR_ENA];
      kb_ctl.of  <= KB_CSR_RST[CSR_OF];
      kb_ctl.ie  <= KB_CSR_RST[CSR_IE];
    end else begin
      if (kb_csr_wr) begin
        kb_ctl.ena <= reg_wdata_i[CSR_ENA];
        kb_ctl.ie  <= reg_wdata_i[CSR_IE];
        if (reg_wdata_i[CSR_OF]) kb_ctl.of <= 1'b0;
      end
      // A new overflow outranks a same-cycle clear so no event is lost
      if (kb_push && kb_full) kb_ctl.of <= 1'b1;
    end
  end

  // Screen CSR: same layout; overflow comes from CPU writes into a full FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      scr_ctl.ena <= SCR_CSR_RST[CSR_ENA];
      scr_ctl.of  <= SCR_CSR_RST[CSR_OF];
      scr_ctl.ie  <= SCR_CSR_RST[CSR_IE];
    end else begin
      if (scr_csr_wr) begin
        scr_ctl.ena <= reg_wdata_i[CSR_ENA];
        scr_ctl.ie  <= reg_wdata_i[CSR_IE];
        if (reg_wdata_i[CSR_OF]) scr_ctl.of <= 1'b0;
      end
      if (scr_push && scr_full) scr_ctl.of <= 1'b1;
    end
  end

  // Read mux over pre-edge state, so a same-cycle write is not yet visible
  always_comb begin
    rd_mux = '0;
    case (reg_sel_i)
      SEL_KB_DATA:  rd_mux = kb_empty ? '0 : kb_head;
      SEL_KB_CSR:   rd_mux = DW'(csr_pack(kb_ctl, kb_dba, KB_CSR_RST[CSR_IO]));
      SEL_SCR_CSR:  rd_mux = DW'(csr_pack(scr_ctl, scr_dba, SCR_CSR_RST[CSR_IO]));
      default:      rd_mux = '0;
    endcase
  end

  // ---- stage p1: registered read data, held between reads ----
  always_ff @(posedge clk) begin
    if (rst)           rdata_p1 <= '0;
    else if (reg_rd_i) rdata_p1 <= rd_mux;
  end

  assign reg_rdata_o = rdata_p1;

`ifdef KB_SCR_IRQ_EN
  logic irq_p1;

  // ---- stage p1: level interrupt from data-available and overflow causes ----
  always_ff @(posedge clk) begin
    if (rst) irq_p1 <= 1'b0;
    else     irq_p1 <= (kb_ctl.ie & kb_dba)
                     | (scr_ctl.ie & scr_ctl.ena & scr_dba)
                     | (kb_ctl.ie & kb_ctl.of)
                     | (scr_ctl.ie & scr_ctl.of);
  end

  assign irq_o = irq_p1;
`else
  assign irq_o = 1'b0;
`endif

endmodule
